// File: rtl/obi_sram_if.sv
// OBI request/response channel between an upstream request driver and the
// SRAM subordinate.
//   master : drives req/addr/we/be/wdata, receives gnt/rvalid/rdata/err
//   slave  : the subordinate side of the same signals
interface obi_sram_if;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/obi_sram_subordinate.sv
// OBI subordinate fronting a single-port 32-bit SRAM.
// A request waits WAIT_STATES cycles (0..7) before it is granted. In the
// grant cycle an in-range request drives the SRAM strobes; an out-of-range
// or misaligned request touches nothing and is answered with err_o. Every
// accepted transfer gets exactly one response in the following cycle.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   bus             OBI slave modport (req/gnt/addr/we/be/wdata/rvalid/rdata/err)
//   sram_csb_o      chip select, active low
//   sram_web_o      write enable, active low
//   sram_wmask_o    byte write mask
//   sram_addr_o     word address
//   sram_din_o      write data
//   sram_dout_i     read data, valid the cycle after a read access
module obi_sram_subordinate #(
    parameter int unsigned MEM_AW      = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    obi_sram_if.slave         bus,
    output logic              sram_csb_o,
    output logic              sram_web_o,
    output logic [3:0]        sram_wmask_o,
    output logic [MEM_AW-1:0] sram_addr_o,
    output logic [31:0]       sram_din_o,
    input  logic [31:0]       sram_dout_i
);

    localparam logic [2:0] WAIT_N = 3'(WAIT_STATES);

    logic [2:0] wait_cnt;
    logic       accept;
    logic       in_range;
    logic       access;
    logic       rsp_vld;
    logic       rsp_we;
    logic       rsp_err;

    // Grant is held low through reset so nothing is accepted while the
    // response registers are being cleared.
    always_comb begin
        bus.gnt_o = 1'b0;
        if (!rst_i) begin
            if (WAIT_STATES == 0) bus.gnt_o = bus.req_i;
            else                  bus.gnt_o = bus.req_i && (wait_cnt == WAIT_N);
        end
    end

    assign accept   = bus.req_i && bus.gnt_o;
    assign in_range = (bus.addr_i[1:0] == 2'b00) &&
                      ((bus.addr_i >> (MEM_AW + 2)) == 32'd0);
    assign access   = accept && in_range;

    // A dropped request restarts the wait from zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || !bus.req_i || accept) wait_cnt <= 3'd0;
        else                               wait_cnt <= wait_cnt + 3'd1;
    end

    assign sram_csb_o   = !access;
    assign sram_web_o   = !(access && bus.we_i);
    assign sram_wmask_o = (access && bus.we_i) ? bus.be_i : 4'b0000;
    assign sram_addr_o  = bus.addr_i[MEM_AW+1:2];
    assign sram_din_o   = bus.wdata_i;

    // Response attributes are latched at acceptance so a request arriving
    // during the response cycle cannot alter the answer going out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_vld <= 1'b0;
            rsp_we  <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            rsp_vld <= accept;
            rsp_we  <= bus.we_i;
            rsp_err <= !in_range;
        end
    end

    // Masking with rst_i kills a response whose cycle coincides with reset;
    // the register is cleared at the same edge, so it never comes back.
    assign bus.rvalid_o = rsp_vld && !rst_i;
    assign bus.err_o    = bus.rvalid_o && rsp_err;
    assign bus.rdata_o  = (bus.rvalid_o && !rsp_we && !rsp_err) ? sram_dout_i : 32'd0;

endmodule

// File: tb/tb_obi_sram_subordinate.sv
module tb_obi_sram_subordinate;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Three instances: WAIT_STATES = 0, 1, 3
    obi_sram_if b0 ();
    obi_sram_if b1 ();
    obi_sram_if b3 ();

    logic        csb0, web0, csb1, web1, csb3, web3;
    logic [3:0]  wm0, wm1, wm3;
    logic [9:0]  ad0, ad1, ad3;
    logic [31:0] di0, di1, di3, do0, do1, do3;

    logic [31:0] mem0 [0:1023];
    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];

    obi_sram_subordinate #(.MEM_AW(10), .WAIT_STATES(0)) u_ws0 (
        .clk_i(clk), .rst_i(rst), .bus(b0),
        .sram_csb_o(csb0), .sram_web_o(web0), .sram_wmask_o(wm0),
        .sram_addr_o(ad0), .sram_din_o(di0), .sram_dout_i(do0));

    obi_sram_subordinate #(.MEM_AW(10), .WAIT_STATES(1)) u_ws1 (
        .clk_i(clk), .rst_i(rst), .bus(b1),
        .sram_csb_o(csb1), .sram_web_o(web1), .sram_wmask_o(wm1),
        .sram_addr_o(ad1), .sram_din_o(di1), .sram_dout_i(do1));

    obi_sram_subordinate #(.MEM_AW(10), .WAIT_STATES(3)) u_ws3 (
        .clk_i(clk), .rst_i(rst), .bus(b3),
        .sram_csb_o(csb3), .sram_web_o(web3), .sram_wmask_o(wm3),
        .sram_addr_o(ad3), .sram_din_o(di3), .sram_dout_i(do3));

    // SRAM behavioural models: byte-masked write, registered read
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++) if (wm0[b]) mem0[ad0][b*8 +: 8] <= di0[b*8 +: 8];
            end else do0 <= mem0[ad0];
        end
    end
    always @(posedge clk) begin
        if (!csb1) begin
            if (!web1) begin
                for (int b = 0; b < 4; b++) if (wm1[b]) mem1[ad1][b*8 +: 8] <= di1[b*8 +: 8];
            end else do1 <= mem1[ad1];
        end
    end
    always @(posedge clk) begin
        if (!csb3) begin
            if (!web3) begin
                for (int b = 0; b < 4; b++) if (wm3[b]) mem3[ad3][b*8 +: 8] <= di3[b*8 +: 8];
            end else do3 <= mem3[ad3];
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        b0.req_i = 1'b1; b0.addr_i = 32'h0;  b0.we_i = 1'b1; b0.be_i = 4'hF; b0.wdata_i = 32'h0;
        b1.req_i = 1'b1; b1.addr_i = 32'h10; b1.we_i = 1'b0; b1.be_i = 4'h0; b1.wdata_i = 32'h0;
        b3.req_i = 1'b0; b3.addr_i = 32'h0;  b3.we_i = 1'b0; b3.be_i = 4'h0; b3.wdata_i = 32'h0;
        next_cycle(); next_cycle(); next_cycle();
        #1;
        checks++; if (b0.gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt0: got %b exp 0", b0.gnt_o); end
        checks++; if (b1.gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b exp 0", b1.gnt_o); end
        checks++; if (csb0 !== 1'b1) begin errors++; $display("FAIL reset_csb: got %b exp 1", csb0); end
        checks++; if (web0 !== 1'b1) begin errors++; $display("FAIL reset_web: got %b exp 1", web0); end
        checks++; if (wm0 !== 4'h0) begin errors++; $display("FAIL reset_wmask: got %h exp 0", wm0); end
        checks++; if (b0.rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b exp 0", b0.rvalid_o); end
        checks++; if (b0.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", b0.err_o); end
        checks++; if (b0.rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", b0.rdata_o); end
        next_cycle();
        // first cycle out of reset: ws1 counter must start at zero
        rst = 1'b0; b0.req_i = 1'b0;
        #1;
        checks++; if (b1.gnt_o !== 1'b0) begin errors++; $display("FAIL reset_cnt_clear: got %b exp 0", b1.gnt_o); end
        next_cycle();
        b1.req_i = 1'b0;
        next_cycle();
    endtask

    task automatic test_read_ws1;
        b1.req_i = 1'b1; b1.addr_i = 32'h10; b1.we_i = 1'b0;
        #1;
        checks++; if (b1.gnt_o !== 1'b0) begin errors++; $display("FAIL rd_wait_gnt: got %b exp 0", b1.gnt_o); end
        checks++; if (csb1 !== 1'b1) begin errors++; $display("FAIL rd_wait_csb: got %b exp 1", csb1); end
        next_cycle();
        #1;
        checks++; if (b1.gnt_o !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b exp 1", b1.gnt_o); end
        checks++; if (csb1 !== 1'b0) begin errors++; $display("FAIL rd_csb: got %b exp 0", csb1); end
        checks++; if (web1 !== 1'b1) begin errors++; $display("FAIL rd_web: got %b exp 1", web1); end
        checks++; if (ad1 !== 10'd4) begin errors++; $display("FAIL rd_addr: got %0d exp 4", ad1); end
        next_cycle();
        b1.req_i = 1'b0;
        #1;
        checks++; if (b1.rvalid_o !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b exp 1", b1.rvalid_o); end
        checks++; if (b1.rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h exp deadbeef", b1.rdata_o); end
        checks++; if (b1.err_o !== 1'b0) begin errors++; $display("FAIL rd_err: got %b exp 0", b1.err_o); end
        next_cycle();
        #1;
        checks++; if (b1.rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_rvalid_drop: got %b exp 0", b1.rvalid_o); end
        checks++; if (b1.rdata_o !== 32'h0) begin errors++; $display("FAIL rd_rdata_idle: got %h exp 0", b1.rdata_o); end
    endtask

    task automatic test_write_ws1;
        next_cycle();
        b1.req_i = 1'b1; b1.addr_i = 32'h8; b1.we_i = 1'b1; b1.be_i = 4'b0011; b1.wdata_i = 32'h12345678;
        next_cycle();
        #1;
        checks++; if (b1.gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b exp 1", b1.gnt_o); end
        checks++; if (csb1 !== 1'b0) begin errors++; $display("FAIL wr_csb: got %b exp 0", csb1); end
        checks++; if (web1 !== 1'b0) begin errors++; $display("FAIL wr_web: got %b exp 0", web1); end
        checks++; if (wm1 !== 4'b0011) begin errors++; $display("FAIL wr_wmask: got %b exp 0011", wm1); end
        checks++; if (ad1 !== 10'd2) begin errors++; $display("FAIL wr_addr: got %0d exp 2", ad1); end
        checks++; if (di1 !== 32'h12345678) begin errors++; $display("FAIL wr_din: got %h exp 12345678", di1); end
        next_cycle();
        b1.req_i = 1'b0; b1.we_i = 1'b0; b1.be_i = 4'h0;
        #1;
        checks++; if (b1.rvalid_o !== 1'b1) begin errors++; $display("FAIL wr_rvalid: got %b exp 1", b1.rvalid_o); end
        checks++; if (b1.rdata_o !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h exp 0", b1.rdata_o); end
        checks++; if (b1.err_o !== 1'b0) begin errors++; $display("FAIL wr_err: got %b exp 0", b1.err_o); end
        checks++; if (mem1[2] !== 32'hAAAA5678) begin errors++; $display("FAIL wr_mem: got %h exp aaaa5678", mem1[2]); end
        next_cycle();
    endtask

    task automatic test_error_ws1;
        logic [31:0] bad [2];
        bad[0] = 32'h1000; bad[1] = 32'h2;
        for (int k = 0; k < 2; k++) begin
            b1.req_i = 1'b1; b1.addr_i = bad[k]; b1.we_i = 1'b0;
            next_cycle();
            #1;
            checks++; if (b1.gnt_o !== 1'b1) begin errors++; $display("FAIL err_gnt[%0d]: got %b exp 1", k, b1.gnt_o); end
            checks++; if (csb1 !== 1'b1) begin errors++; $display("FAIL err_csb[%0d]: got %b exp 1", k, csb1); end
            next_cycle();
            b1.req_i = 1'b0;
            #1;
            checks++; if (b1.rvalid_o !== 1'b1) begin errors++; $display("FAIL err_rvalid[%0d]: got %b exp 1", k, b1.rvalid_o); end
            checks++; if (b1.err_o !== 1'b1) begin errors++; $display("FAIL err_err[%0d]: got %b exp 1", k, b1.err_o); end
            checks++; if (b1.rdata_o !== 32'h0) begin errors++; $display("FAIL err_rdata[%0d]: got %h exp 0", k, b1.rdata_o); end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] va [6];
        logic        vw [6];
        logic        ecsb [6];
        logic [31:0] erd [6];
        logic        eerr [6];
        va = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h2, 32'h4};
        vw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ecsb = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        erd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h0, 32'h0};
        eerr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 7; k++) begin
            if (k < 6) begin
                b0.req_i = 1'b1; b0.addr_i = va[k]; b0.we_i = vw[k]; b0.be_i = 4'hF; b0.wdata_i = 32'h55AA55AA;
            end else begin
                b0.req_i = 1'b0; b0.we_i = 1'b0;
            end
            #1;
            if (k < 6) begin
                checks++; if (b0.gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b exp 1", k, b0.gnt_o); end
                checks++; if (csb0 !== ecsb[k]) begin errors++; $display("FAIL b2b_csb[%0d]: got %b exp %b", k, csb0, ecsb[k]); end
            end
            if (k > 0) begin
                checks++; if (b0.rvalid_o !== 1'b1) begin errors++; $display("FAIL b2b_rvalid[%0d]: got %b exp 1", k, b0.rvalid_o); end
                checks++; if (b0.rdata_o !== erd[k-1]) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h exp %h", k, b0.rdata_o, erd[k-1]); end
                checks++; if (b0.err_o !== eerr[k-1]) begin errors++; $display("FAIL b2b_err[%0d]: got %b exp %b", k, b0.err_o, eerr[k-1]); end
            end
            next_cycle();
        end
        #1;
        checks++; if (b0.rvalid_o !== 1'b0) begin errors++; $display("FAIL b2b_rvalid_end: got %b exp 0", b0.rvalid_o); end
        checks++; if (mem0[1] !== 32'h55AA55AA) begin errors++; $display("FAIL b2b_wr_mem: got %h exp 55aa55aa", mem0[1]); end
        next_cycle();
    endtask

    task automatic test_reset_mid;
        b0.req_i = 1'b1; b0.addr_i = 32'h8; b0.we_i = 1'b0;
        #1;
        checks++; if (b0.gnt_o !== 1'b1) begin errors++; $display("FAIL rstm_gnt: got %b exp 1", b0.gnt_o); end
        next_cycle();
        rst = 1'b1; b0.req_i = 1'b0;
        #1;
        checks++; if (b0.rvalid_o !== 1'b0) begin errors++; $display("FAIL rstm_suppress: got %b exp 0", b0.rvalid_o); end
        checks++; if (b0.rdata_o !== 32'h0) begin errors++; $display("FAIL rstm_rdata: got %h exp 0", b0.rdata_o); end
        next_cycle();
        rst = 1'b0; b0.req_i = 1'b1; b0.addr_i = 32'hC;
        #1;
        checks++; if (b0.rvalid_o !== 1'b0) begin errors++; $display("FAIL rstm_no_replay: got %b exp 0", b0.rvalid_o); end
        checks++; if (b0.gnt_o !== 1'b1) begin errors++; $display("FAIL rstm_first_gnt: got %b exp 1", b0.gnt_o); end
        next_cycle();
        b0.req_i = 1'b0;
        #1;
        checks++; if (b0.rvalid_o !== 1'b1) begin errors++; $display("FAIL rstm_rvalid: got %b exp 1", b0.rvalid_o); end
        checks++; if (b0.rdata_o !== 32'h44444444) begin errors++; $display("FAIL rstm_rdata2: got %h exp 44444444", b0.rdata_o); end
        next_cycle();
    endtask

    task automatic test_wait_abort;
        logic ereq [8];
        logic egnt [8];
        ereq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        egnt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        b3.addr_i = 32'hC; b3.we_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            b3.req_i = ereq[k];
            #1;
            checks++; if (b3.gnt_o !== egnt[k]) begin errors++; $display("FAIL ws3_gnt[%0d]: got %b exp %b", k, b3.gnt_o, egnt[k]); end
            checks++; if (csb3 !== !egnt[k]) begin errors++; $display("FAIL ws3_csb[%0d]: got %b exp %b", k, csb3, !egnt[k]); end
            checks++; if (b3.rvalid_o !== (k == 7)) begin errors++; $display("FAIL ws3_rvalid[%0d]: got %b exp %b", k, b3.rvalid_o, (k == 7)); end
            if (k == 7) begin
                checks++; if (b3.rdata_o !== 32'hCAFEF00D) begin errors++; $display("FAIL ws3_rdata: got %h exp cafef00d", b3.rdata_o); end
            end
            next_cycle();
        end
    endtask

    initial begin
        mem0[0] = 32'h11111111; mem0[1] = 32'h22222222;
        mem0[2] = 32'h33333333; mem0[3] = 32'h44444444;
        mem1[2] = 32'hAAAAAAAA; mem1[4] = 32'hDEADBEEF;
        mem3[3] = 32'hCAFEF00D;
        test_reset();
        test_read_ws1();
        test_write_ws1();
        test_error_ws1();
        test_back_to_back();
        test_reset_mid();
        test_wait_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
